// File: rtl/mrsc_stream_encoder_if.sv
// Stream interface for mrsc_stream_encoder: data in, codeword out, counter access.
// With MRSC_ERR_INJECT_EN defined it also carries the error-injection controls.
interface mrsc_stream_encoder_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      out_word;
  logic             out_valid;
  logic             out_ready;
  logic             cnt_clr;
  logic [CNT_W-1:0] enc_count;
`ifdef MRSC_ERR_INJECT_EN
  logic             inj_en;
  logic [31:0]      inj_mask;

  modport master (
    output in_data, in_valid, out_ready, cnt_clr, inj_en, inj_mask,
    input  in_ready, out_word, out_valid, enc_count
  );
  modport slave (
    input  in_data, in_valid, out_ready, cnt_clr, inj_en, inj_mask,
    output in_ready, out_word, out_valid, enc_count
  );
`else
  modport master (
    output in_data, in_valid, out_ready, cnt_clr,
    input  in_ready, out_word, out_valid, enc_count
  );
  modport slave (
    input  in_data, in_valid, out_ready, cnt_clr,
    output in_ready, out_word, out_valid, enc_count
  );
`endif
endinterface

// File: rtl/mrsc_stream_encoder.sv
// Streaming MRSC encoder: 16-bit word -> 32-bit codeword through a 2-entry skid buffer.
// Optional macro MRSC_ERR_INJECT_EN XORs inj_mask into the stored codeword when inj_en is set.
module mrsc_stream_encoder #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mrsc_stream_encoder_if.slave  bus
);
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HALF  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  // Rows are nibbles A..D (MSB first); bit 3 of a nibble is column 1.
  function automatic logic [31:0] mrsc_encode(input logic [15:0] d);
    logic [3:0] a, b, c, e, p;
    logic       di1, di2, di3, di4;
    a   = d[15:12];
    b   = d[11:8];
    c   = d[7:4];
    e   = d[3:0];
    p   = a ^ b ^ c ^ e;
    di1 = a[3] ^ b[2] ^ c[3] ^ e[2];
    di2 = a[2] ^ b[3] ^ c[2] ^ e[3];
    di3 = a[1] ^ b[0] ^ c[1] ^ e[0];
    di4 = a[0] ^ b[1] ^ c[0] ^ e[1];
    return {d, di1, di3, di2, di4, p[3], p[1], p[2], p[0],
            a[3] ^ a[1], a[2] ^ a[0], b[3] ^ b[1], b[2] ^ b[0],
            c[3] ^ c[1], c[2] ^ c[0], e[3] ^ e[1], e[2] ^ e[0]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       state, state_nxt;
  logic             in_ready_q;
  logic             out_valid;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      enc_word_p0;
  logic [31:0]      main_word_p1, skid_word_p1;
  logic             push, pop, load_main, load_skid, shift_skid;

  // Stage p0: combinational encode of the offered word
`ifdef MRSC_ERR_INJECT_EN
  assign enc_word_p0 = mrsc_encode(bus.in_data) ^ (bus.inj_en ? bus.inj_mask : 32'h0);
`else
  assign enc_word_p0 = mrsc_encode(bus.in_data);
`endif

  assign out_valid     = (state != S_EMPTY);
  assign push          = bus.in_valid && in_ready_q;
  assign pop           = out_valid && bus.out_ready;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_word  = main_word_p1;
  assign bus.enc_count = cnt_q;

  always_comb begin
    state_nxt  = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    case (state)
      S_EMPTY: if (push) begin
        state_nxt = S_HALF;
        load_main = 1'b1;
      end
      S_HALF: begin
        if (push && !pop) begin
          state_nxt = S_FULL;
          load_skid = 1'b1;
        end else if (push && pop) begin
          load_main = 1'b1;
        end else if (pop) begin
          state_nxt = S_EMPTY;
        end
      end
      S_FULL: if (pop) begin
        state_nxt  = S_HALF;
        shift_skid = 1'b1;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // in_ready is registered from the next state so it never follows out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != S_FULL);
      if (bus.cnt_clr)
        cnt_q <= '0;
      else if (pop)
        cnt_q <= sat_inc(cnt_q);
    end
  end

  // Stage p1: main output register and skid register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_word_p1 <= '0;
      skid_word_p1 <= '0;
    end else begin
      if (load_main)
        main_word_p1 <= enc_word_p0;
      else if (shift_skid)
        main_word_p1 <= skid_word_p1;
      if (load_skid)
        skid_word_p1 <= enc_word_p0;
    end
  end
endmodule

// File: tb/tb_mrsc_stream_encoder.sv
// Scoreboard bench for mrsc_stream_encoder: ordering, back-pressure, counter, reset.
// Define MRSC_ERR_INJECT_EN for both files to also exercise error injection.
module tb_mrsc_stream_encoder;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [31:0] sb[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  mrsc_stream_encoder_if #(.CNT_W(CNT_W)) bus ();

  mrsc_stream_encoder #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] d);
    logic       m [4][4];
    logic [3:0] p;
    logic [3:0] di;
    logic [7:0] x;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = d[15 - 4*r - c];
    for (int c = 0; c < 4; c++)
      p[c] = m[0][c] ^ m[1][c] ^ m[2][c] ^ m[3][c];
    di[0] = m[0][0] ^ m[1][1] ^ m[2][0] ^ m[3][1];
    di[1] = m[0][1] ^ m[1][0] ^ m[2][1] ^ m[3][0];
    di[2] = m[0][2] ^ m[1][3] ^ m[2][2] ^ m[3][3];
    di[3] = m[0][3] ^ m[1][2] ^ m[2][3] ^ m[3][2];
    for (int r = 0; r < 4; r++) begin
      x[7 - 2*r] = m[r][0] ^ m[r][2];
      x[6 - 2*r] = m[r][1] ^ m[r][3];
    end
    return {d, di[0], di[2], di[1], di[3], p[0], p[2], p[1], p[3], x};
  endfunction

  // Called just after a negedge with inputs set; samples handshakes, returns at the next negedge.
  task automatic tick();
    logic [31:0] inj;
    inj = 32'h0;
`ifdef MRSC_ERR_INJECT_EN
    if (bus.inj_en) inj = bus.inj_mask;
`endif
    #1;
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_word);
      exp_q.push_back(sb.size() != 0 ? sb.pop_front() : 32'hxxxxxxxx);
    end
    if (bus.in_valid && bus.in_ready)
      sb.push_back(model(bus.in_data) ^ inj);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_flags: got valid=%b ready=%b, required valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    n_cmp++;
    if (bus.enc_count !== '0 || bus.out_word !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: got count=%0d word=%h, required 0 and 0", bus.enc_count, bus.out_word);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h80FA;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h80FA4B80) begin
      n_err++;
      $display("FAIL basic_word: got valid=%b word=%h, required 1 80fa4b80", bus.out_valid, bus.out_word);
    end
    tick();
    n_cmp++;
    if (bus.enc_count !== 4'd1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_count: got count=%0d valid=%b, required 1 0", bus.enc_count, bus.out_valid);
    end
    while (got_q.size() != 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL basic_sb: got %h, required %h", got_q[0], exp_q[0]);
      end
      void'(got_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0000;
    tick();
    bus.in_data = 16'hFFFF;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h00000000) begin
      n_err++;
      $display("FAIL b2b_first: got valid=%b word=%h, required 1 00000000", bus.out_valid, bus.out_word);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 32'hFFFF0000) begin
      n_err++;
      $display("FAIL b2b_second: got valid=%b word=%h, required 1 ffff0000", bus.out_valid, bus.out_word);
    end
    tick();
    while (got_q.size() != 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL b2b_sb: got %h, required %h", got_q[0], exp_q[0]);
      end
      void'(got_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr   = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0001;
    tick();
    bus.in_data = 16'h0002;
    tick();
    bus.in_data = 16'h0003;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full_ready: got in_ready=%b, required 0", bus.in_ready);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_word !== 32'h00014101) begin
      n_err++;
      $display("FAIL bp_hold: got ready=%b valid=%b word=%h, required 0 1 00014101", bus.in_ready, bus.out_valid, bus.out_word);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && (bus.in_valid || sb.size() != 0 || bus.out_valid); i++) begin
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) bus.in_valid = 1'b0;
    end
    n_cmp++;
    if (bus.in_valid || sb.size() != 0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_timeout: got pending=%0d in_valid=%b, required all drained", sb.size(), bus.in_valid);
      bus.in_valid = 1'b0;
    end
    n_cmp++;
    if (bus.enc_count !== 4'd3 || got_q.size() != 3) begin
      n_err++;
      $display("FAIL bp_count: got count=%0d outputs=%0d, required 3 3", bus.enc_count, got_q.size());
    end
    while (got_q.size() != 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL bp_sb: got %h, required %h", got_q[0], exp_q[0]);
      end
      void'(got_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_stream8();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'($urandom);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL s8_ready: cycle %0d got in_ready=%b, required 1", i, bus.in_ready);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL s8_valid: cycle %0d got out_valid=%b, required 1", i, bus.out_valid);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus.enc_count !== 4'd8 || got_q.size() != 8) begin
      n_err++;
      $display("FAIL s8_count: got count=%0d outputs=%0d, required 8 8", bus.enc_count, got_q.size());
    end
    while (got_q.size() != 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL s8_sb: got %h, required %h", got_q[0], exp_q[0]);
      end
      void'(got_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_saturate();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 16'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus.enc_count !== 4'd15) begin
      n_err++;
      $display("FAIL sat_count: got %0d, required 15", bus.enc_count);
    end
    while (got_q.size() != 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL sat_sb: got %h, required %h", got_q[0], exp_q[0]);
      end
      void'(got_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_clr_and_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    bus.cnt_clr  = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    n_cmp++;
    if (bus.enc_count !== 4'd0) begin
      n_err++;
      $display("FAIL clr_with_pop: got %0d, required 0", bus.enc_count);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hA5C3;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0F0F;
    tick();
    bus.in_data = 16'h7E81;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.enc_count !== 4'd1) begin
      n_err++;
      $display("FAIL full_state: got ready=%b valid=%b count=%0d, required 0 1 1", bus.in_ready, bus.out_valid, bus.enc_count);
    end
    while (got_q.size() != 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL clr_sb: got %h, required %h", got_q[0], exp_q[0]);
      end
      void'(got_q.pop_front());
      void'(exp_q.pop_front());
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.enc_count !== 4'd0) begin
      n_err++;
      $display("FAIL async_reset: got valid=%b ready=%b count=%0d, required 0 1 0", bus.out_valid, bus.in_ready, bus.enc_count);
    end
    sb.delete();
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++;
      if (bus.out_valid !== (sb.size() != 0) || bus.in_ready !== (sb.size() < 2)) begin
        n_err++;
        $display("FAIL rnd_occupancy: cycle %0d got valid=%b ready=%b, required occupancy %0d", i, bus.out_valid, bus.in_ready, sb.size());
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && (sb.size() != 0 || bus.out_valid); i++)
      tick();
    n_cmp++;
    if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rnd_drain: got pending=%0d valid=%b, required 0 0", sb.size(), bus.out_valid);
    end
    while (got_q.size() != 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL rnd_sb: got %h, required %h", got_q[0], exp_q[0]);
      end
      void'(got_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask

`ifdef MRSC_ERR_INJECT_EN
  task automatic test_inject();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h80FA;
    bus.inj_en    = 1'b1;
    bus.inj_mask  = 32'h30000000;
    tick();
    bus.in_valid = 1'b0;
    bus.inj_en   = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 32'hB0FA4B80) begin
      n_err++;
      $display("FAIL inject_word: got valid=%b word=%h, required 1 b0fa4b80", bus.out_valid, bus.out_word);
    end
    tick();
    while (got_q.size() != 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL inject_sb: got %h, required %h", got_q[0], exp_q[0]);
      end
      void'(got_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask
`endif

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_data   = 16'h0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.cnt_clr   = 1'b0;
`ifdef MRSC_ERR_INJECT_EN
    bus.inj_en    = 1'b0;
    bus.inj_mask  = 32'h0;
`endif
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_stream8();
    test_saturate();
    test_clr_and_reset();
    test_random();
`ifdef MRSC_ERR_INJECT_EN
    test_inject();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mrsc_stream_encoder.md
Name: mrsc_stream_encoder

Overview:
Streaming MRSC (Matrix Region Selection Code) encoder, the transmit-side counterpart of mrsc_decoder. It takes 16-bit data words over a valid/ready interface and computes 4 diagonal, 4 parity and 8 check bits. It emits the 32-bit codeword through a 2-entry skid buffer, so full throughput is sustained under back-pressure. An encoded-word counter supports link statistics.

Parameters:
CNT_W, 16, width of the encoded-word counter (>=1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  16  data word to encode
in_valid  in  1  in_data is valid
in_ready  out  1  encoder can accept a word this cycle
out_word  out  32  MRSC codeword, layout identical to mrsc_decoder in_word
out_valid  out  1  out_word is valid
out_ready  in  1  downstream accepts out_word
cnt_clr  in  1  synchronous clear of enc_count
enc_count  out  CNT_W  number of completed output handshakes, saturating

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Matrix: rows A=in_data[15:12], B=[11:8], C=[7:4], D=[3:0]. Columns 1..4 are numbered MSB to LSB within a row, so A1=in_data[15] and A4=in_data[12].
- Parity: Pk = Ak^Bk^Ck^Dk, for k=1..4.
- Diagonals:
  - DI1 = A1^B2^C1^D2
  - DI2 = A2^B1^C2^D1
  - DI3 = A3^B4^C3^D4
  - DI4 = A4^B3^C4^D3
- Check bits, per row R in {A,B,C,D}: XR_1_3 = R1^R3 and XR_2_4 = R2^R4.
- Codeword layout:
  - out_word[31:16] = in_data
  - [15:12] = {DI1,DI3,DI2,DI4}
  - [11:8] = {P1,P3,P2,P4}
  - [7:0] = {XA_1_3,XA_2_4,XB_1_3,XB_2_4,XC_1_3,XC_2_4,XD_1_3,XD_2_4}
- Encoding is combinational on in_data. The result is registered on accept (in_valid && in_ready).
- Latency: a word accepted in cycle N appears on out_word with out_valid=1 in cycle N+1.
- Buffer FSM:
  - EMPTY: out_valid=0, in_ready=1.
  - HALF: main register full, out_valid=1, in_ready=1.
  - FULL: main and skid full, out_valid=1, in_ready=0.
- Transitions (push = accept, pop = out_valid && out_ready):
  - EMPTY + push -> HALF.
  - HALF + push, no pop -> FULL (new word goes to skid).
  - HALF + pop, no push -> EMPTY.
  - HALF + push + pop -> HALF (main reloaded with new word).
  - FULL + pop -> HALF (skid moves to main). Push is impossible in FULL.
- in_ready is a registered output, equal to (next state != FULL). It never depends combinationally on out_ready.
- out_word and out_valid hold stable while out_valid && !out_ready. Words leave strictly in acceptance order, with no drop or duplicate.
- enc_count:
  - +1 per pop, saturating at 2^CNT_W-1.
  - cnt_clr has priority: cnt_clr and pop in the same cycle -> 0.
- Reset values: state EMPTY, out_valid=0, out_word=0, in_ready=1, enc_count=0, skid register=0.
  - Reset mid-operation discards buffered words.
  - First accept is possible on the first clk edge after rst_n deasserts.
- in_data is ignored when in_valid=0. in_valid asserted in FULL has no effect.

Optional Feature:
MRSC_ERR_INJECT_EN:
- Defined:
  - Adds inputs inj_en (1) and inj_mask (32).
  - On accept with inj_en=1, the stored word is the encoded word XOR inj_mask. The mask is sampled in the same cycle as in_data.
  - Lets the bench drive decoder error paths.
- Undefined: the ports do not exist and the codeword is always the clean encoding.

Test Plan:
- Reset, out_ready=1, push 16'h80FA -> next cycle out_valid=1, out_word=32'h80FA4B80, enc_count=1 after pop.
- Push 16'h0000 then 16'hFFFF back-to-back -> out_word=32'h00000000 then 32'hFFFF0000 on consecutive cycles.
- out_ready=0, offer 3 words (16'h0001, 16'h0002, 16'h0003):
  - first two accepted, in_ready=0 the cycle after the second accept, third held;
  - raise out_ready -> outputs arrive in order 1,2,3, each a correct codeword, enc_count=3.
- out_ready=1, 8 back-to-back pushes -> 8 pops on 8 consecutive cycles, in_ready stays 1, enc_count=8.
- cnt_clr asserted in the same cycle as a pop -> enc_count=0. Then assert rst_n=0 while in FULL -> out_valid=0, in_ready=1, enc_count=0 immediately.
- With MRSC_ERR_INJECT_EN: push 16'h80FA, inj_en=1, inj_mask=32'h30000000 -> out_word=32'hB0FA4B80. Feeding this to mrsc_decoder gives decoded_word=16'h80FA.
